// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Summary  : Matrix keypad row scanner with frame-level key resolution,
//            multi-frame debounce and a valid/ack press-event interface.
// Revision : 1.0  initial release
// ============================================================================
module keypad_scan_ctrl #(
    parameter int ROWS     = 4,
    parameter int COLS     = 3,
    parameter int DWELL    = 1000,
    parameter int DEBOUNCE = 4,
    parameter int CODE_W   = $clog2(ROWS*COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [COLS-1:0]   cols,
    output logic [ROWS-1:0]   rows,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    input  logic              key_ack,
    output logic              key_held,
    output logic              multi,
    output logic              overrun
);

    localparam int ROW_W   = $clog2(ROWS);
    localparam int DWELL_W = $clog2(DWELL);
    localparam int CNT_W   = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        KIND_NONE  = 2'b00,
        KIND_KEY   = 2'b01,
        KIND_MULTI = 2'b10
    } kind_e;

    logic [COLS-1:0]    cols_meta_q, cols_sync_q;
    logic [ROWS-1:0]    rows_q;
    logic [ROW_W-1:0]   row_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [1:0]         hits_q;
    logic [CODE_W-1:0]  first_q;
    kind_e              cand_kind_q, acc_kind_q;
    logic [CODE_W-1:0]  cand_idx_q, acc_idx_q;
    logic [CNT_W-1:0]   stab_q;
    logic               evt_q;
    logic [CODE_W-1:0]  evt_code_q;
    logic               key_valid_q, overrun_q;
    logic [CODE_W-1:0]  key_code_q;

    logic               last_dwell_d, frame_end_d;
    logic [CODE_W-1:0]  row_base_d, row_first_d, first_sum_d, res_idx_d;
    logic [1:0]         row_cnt_d, hits_sum_d;
    logic [2:0]         hits_tmp_d;
    kind_e              res_kind_d;
    logic [CNT_W-1:0]   stab_d;
    logic               accept_d, press_d;

    assign last_dwell_d = (dwell_q == DWELL_W'(DWELL - 1));
    assign frame_end_d  = last_dwell_d && (row_q == ROW_W'(ROWS - 1));
    assign row_base_d   = CODE_W'(row_q) * CODE_W'(COLS);

    // Resolve the current row sample, fold it into the frame and debounce it
    always_comb begin
        row_cnt_d   = 2'd0;
        row_first_d = row_base_d;
        // Descending walk so the lowest set column is the one left standing
        for (int c = COLS - 1; c >= 0; c--) begin
            if (cols_sync_q[c]) begin
                row_first_d = row_base_d + CODE_W'(c);
                if (row_cnt_d != 2'd2) begin
                    row_cnt_d = row_cnt_d + 2'd1;
                end
            end
        end
        hits_tmp_d  = {1'b0, hits_q} + {1'b0, row_cnt_d};
        hits_sum_d  = (hits_tmp_d >= 3'd2) ? 2'd2 : hits_tmp_d[1:0];
        // Earlier rows win: adopt this row's hit only when the frame has no prior hits
        first_sum_d = (hits_q == 2'd0) ? row_first_d : first_q;

        res_kind_d = KIND_NONE;
        res_idx_d  = '0;
        if (hits_sum_d == 2'd1) begin
            res_kind_d = KIND_KEY;
            res_idx_d  = first_sum_d;
        end else if (hits_sum_d == 2'd2) begin
            res_kind_d = KIND_MULTI;
        end

        if ((res_kind_d == cand_kind_q) && (res_idx_d == cand_idx_q)) begin
            stab_d = (stab_q == CNT_W'(DEBOUNCE)) ? stab_q : stab_q + CNT_W'(1);
        end else begin
            stab_d = CNT_W'(1);
        end
        accept_d = (stab_d == CNT_W'(DEBOUNCE));
        // A press is a newly accepted key that differs from the accepted one
        press_d  = accept_d && (res_kind_d == KIND_KEY) &&
                   ((acc_kind_q != KIND_KEY) || (acc_idx_q != res_idx_d));
    end

    // Column synchronizer, row sequencing and per-frame accumulation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cols_meta_q <= '0;
            cols_sync_q <= '0;
            rows_q      <= ROWS'(1);
            row_q       <= '0;
            dwell_q     <= '0;
            hits_q      <= 2'd0;
            first_q     <= '0;
        end else begin
            cols_meta_q <= cols;
            cols_sync_q <= cols_meta_q;
            if (last_dwell_d) begin
                dwell_q <= '0;
                rows_q  <= {rows_q[ROWS-2:0], rows_q[ROWS-1]};
                if (frame_end_d) begin
                    row_q   <= '0;
                    hits_q  <= 2'd0;
                    first_q <= '0;
                end else begin
                    row_q   <= row_q + ROW_W'(1);
                    hits_q  <= hits_sum_d;
                    first_q <= first_sum_d;
                end
            end else begin
                dwell_q <= dwell_q + DWELL_W'(1);
            end
        end
    end

    // Frame-rate debounce, accepted state and press-event registration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_kind_q <= KIND_NONE;
            cand_idx_q  <= '0;
            stab_q      <= '0;
            acc_kind_q  <= KIND_NONE;
            acc_idx_q   <= '0;
            evt_q       <= 1'b0;
            evt_code_q  <= '0;
        end else begin
            evt_q <= frame_end_d && press_d;
            if (frame_end_d) begin
                cand_kind_q <= res_kind_d;
                cand_idx_q  <= res_idx_d;
                stab_q      <= stab_d;
                if (accept_d) begin
                    acc_kind_q <= res_kind_d;
                    acc_idx_q  <= res_idx_d;
                end
                if (press_d) begin
                    evt_code_q <= res_idx_d;
                end
            end
        end
    end

    // Valid/ack handshake with sticky overrun on dropped events
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            overrun_q   <= 1'b0;
        end else if (evt_q) begin
            if (!key_valid_q || key_ack) begin
                key_valid_q <= 1'b1;
                key_code_q  <= evt_code_q;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (key_valid_q && key_ack) begin
            key_valid_q <= 1'b0;
        end
    end

    assign rows      = rows_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign overrun   = overrun_q;
    assign key_held  = (acc_kind_q == KIND_KEY);
    assign multi     = (acc_kind_q == KIND_MULTI);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_ctrl
// Summary  : Directed bench for keypad_scan_ctrl (4x3 keypad, short dwell).
// Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scan_ctrl;

    localparam int ROWS     = 4;
    localparam int COLS     = 3;
    localparam int DWELL    = 4;
    localparam int DEBOUNCE = 4;
    localparam int CODE_W   = 4;
    localparam int FRAME    = ROWS * DWELL;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [COLS-1:0]   cols;
    logic [ROWS-1:0]   rows;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_ack;
    logic              key_held;
    logic              multi;
    logic              overrun;

    logic [ROWS*COLS-1:0] keys;
    int errors = 0;
    int checks = 0;

    keypad_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .DEBOUNCE(DEBOUNCE), .CODE_W(CODE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cols(cols), .rows(rows),
        .key_valid(key_valid), .key_code(key_code), .key_ack(key_ack),
        .key_held(key_held), .multi(multi), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Switch matrix model: a column reads high when a pressed key sits on the driven row
    always_comb begin
        cols = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (rows[r] && keys[r*COLS + c]) cols[c] = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stop on the first cycle of a frame (row 0 freshly driven after row 3)
    task automatic align_frame();
        int guard = 0;
        logic [ROWS-1:0] prev;
        prev = rows;
        @(negedge clk);
        while (!(prev == 4'b1000 && rows == 4'b0001) && guard < 64) begin
            prev = rows;
            @(negedge clk);
            guard++;
        end
        check("frame_align_timeout", 32'(guard < 64), 1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (key_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, key_valid, 1);
    endtask

    task automatic ack_pulse(input string tag);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        check(tag, key_valid, 0);
    endtask

    task automatic watch_no_event(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (key_valid) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ROWS-1:0] exp_rows;
        rst_n   = 1'b0;
        key_ack = 1'b0;
        keys    = '0;

        // Reset and scan sequence
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_rows", rows, 4'b0001);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_held", key_held, 0);
        check("rst_multi", multi, 0);
        check("rst_overrun", overrun, 0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_rows = 4'b0001 << ((k / DWELL) % ROWS);
            check("scan_rows", rows, exp_rows);
            check("scan_valid", key_valid, 0);
            check("scan_overrun", overrun, 0);
        end

        // Single press of key 7 (row 2, col 1), aligned to a frame start
        align_frame();
        keys = 12'h080;
        tick(DEBOUNCE * FRAME);
        check("press_not_early", key_valid, 0);
        tick(1);
        check("press_latency", key_valid, 1);
        check("press_code", key_code, 7);
        check("press_held", key_held, 1);
        ack_pulse("press_ack_fall");
        watch_no_event("press_single_event", 10 * FRAME - DEBOUNCE * FRAME - 2);
        check("press_still_held", key_held, 1);
        keys = '0;
        tick(6 * FRAME);
        check("release_held", key_held, 0);
        check("release_valid", key_valid, 0);

        // Bounce on key 0: toggles each frame for six frames, then holds
        align_frame();
        for (int f = 0; f < 6; f++) begin
            keys = (f % 2 == 0) ? 12'h001 : 12'h000;
            watch_no_event("bounce_no_event", FRAME);
        end
        keys = 12'h001;
        tick(DEBOUNCE * FRAME);
        check("bounce_not_early", key_valid, 0);
        tick(1);
        check("bounce_event", key_valid, 1);
        check("bounce_code", key_code, 0);
        ack_pulse("bounce_ack_fall");
        keys = '0;
        tick(6 * FRAME);

        // Multi-key and rollover
        keys = 12'h030;
        tick(6 * FRAME);
        check("multi_flag", multi, 1);
        check("multi_not_held", key_held, 0);
        check("multi_no_event", key_valid, 0);
        keys = 12'h010;
        wait_valid("multi_release", 6 * FRAME);
        check("multi_release_code", key_code, 4);
        check("multi_release_flag", multi, 0);
        ack_pulse("multi_release_ack");
        keys = 12'h800;
        wait_valid("rollover", 6 * FRAME);
        check("rollover_code", key_code, 11);
        ack_pulse("rollover_ack");
        keys = '0;
        tick(6 * FRAME);
        check("rollover_release_held", key_held, 0);

        // Overrun: press 3, then 6, without acknowledging
        keys = 12'h008;
        wait_valid("ovr_first", 6 * FRAME);
        check("ovr_first_code", key_code, 3);
        keys = 12'h040;
        tick(6 * FRAME);
        check("ovr_code_kept", key_code, 3);
        check("ovr_valid_kept", key_valid, 1);
        check("ovr_flag", overrun, 1);
        check("ovr_held", key_held, 1);
        ack_pulse("ovr_ack_fall");
        check("ovr_sticky_after_ack", overrun, 1);
        keys = '0;
        tick(6 * FRAME);
        check("ovr_sticky_later", overrun, 1);

        // Reset with an event pending discards it and clears overrun
        keys = 12'h008;
        wait_valid("pre_reset", 6 * FRAME);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_code", key_code, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_rows", rows, 4'b0001);

        // Ack collision: ack lands on the cycle the key 9 event registers
        wait_valid("coll_setup", 6 * FRAME);
        check("coll_setup_code", key_code, 3);
        align_frame();
        keys = 12'h200;
        tick(DEBOUNCE * FRAME);
        check("coll_pre_code", key_code, 3);
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        check("coll_valid", key_valid, 1);
        check("coll_code", key_code, 9);
        check("coll_overrun", overrun, 0);
        ack_pulse("coll_final_ack");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
